// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder at the dcache end of the LSU interface.
// Serves one load or store at a time after a fixed LATENCY, backed by an
// internal array of 8-byte words. Optional misalignment checking is enabled
// with the DMEM_MISALIGN_CHECK_EN macro, which also adds the misalign_o port.
module dmem_resp #(
    parameter int LATENCY          = 2,
    parameter int MEM_DEPTH        = 1024,
    parameter int XLEN             = 64,
    parameter int VIRTUAL_ADDR_LEN = 64
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        req_valid_i,
    input  logic                        req_opcode_i,
    input  logic [1:0]                  req_size_i,
    input  logic [VIRTUAL_ADDR_LEN-1:0] req_addr_i,
    input  logic [XLEN-1:0]             req_data_i,
    output logic                        req_ready_o,
    output logic                        resp_valid_o,
    output logic [XLEN-1:0]             resp_data_o,
    input  logic                        resp_ready_i
`ifdef DMEM_MISALIGN_CHECK_EN
    ,
    output logic                        misalign_o
`endif
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int CW = $clog2(LATENCY + 1);
    localparam int NB = XLEN / 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] data_q;
    logic            mis_q;

    logic [XLEN-1:0] mem [MEM_DEPTH];

    logic [AW-1:0]   word_idx;
    logic [2:0]      offset;
    logic [5:0]      shamt;
    logic [XLEN-1:0] size_mask;
    logic [NB-1:0]   size_be;
    logic [XLEN-1:0] load_word;
    logic [XLEN-1:0] wr_data;
    logic [NB-1:0]   wr_be;
    logic            is_mis;
    logic            done_act;

    // resp_ready_i never throttles the response; upper address bits alias.
    logic unused_bits;
    assign unused_bits = ^{resp_ready_i, req_addr_i};

    assign word_idx = req_addr_i[3 +: AW];
    assign offset   = req_addr_i[2:0];
    assign shamt    = {offset, 3'b000};

    // Size decode into a data mask and a byte-enable mask.
    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        size_mask = '1;
        size_be   = '1;
        case (req_size_i)
            2'd0: begin size_mask = XLEN'(8'hFF);        size_be = NB'(8'h01); end
            2'd1: begin size_mask = XLEN'(16'hFFFF);     size_be = NB'(8'h03); end
            2'd2: begin size_mask = XLEN'(32'hFFFF_FFFF); size_be = NB'(8'h0F); end
            default: ;
        endcase
    end

    // Shifting right/left by the byte offset naturally drops bytes that
    // would cross the 8-byte word boundary.
    assign load_word = (mem[word_idx] >> shamt) & size_mask;
    assign wr_data   = req_data_i << shamt;
    assign wr_be     = size_be << offset;

`ifdef DMEM_MISALIGN_CHECK_EN
    logic [2:0] align_mask;
    // Low-address bits that must be zero for the requested size.
    always_comb begin
        align_mask = 3'b000;
        case (req_size_i)
            2'd1:    align_mask = 3'b001;
            2'd2:    align_mask = 3'b011;
            2'd3:    align_mask = 3'b111;
            default: align_mask = 3'b000;
        endcase
    end
    assign is_mis = |(offset & align_mask);
`else
    assign is_mis = 1'b0;
`endif

    // Next-state logic: detect, count down the latency, complete.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req_valid_i) state_next = (LATENCY == 1 || is_mis) ? DONE : WAIT;
            WAIT: begin
                if (!req_valid_i)          state_next = IDLE;
                else if (cnt == CW'(1))    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register and latency counter.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid_i) cnt <= CW'(LATENCY - 1);
            else if (state == WAIT)           cnt <= cnt - CW'(1);
        end
    end

    // Capture load data and the misalignment flag on entry to DONE.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            data_q <= '0;
            mis_q  <= 1'b0;
        end else if (state != DONE && state_next == DONE) begin
            data_q <= is_mis ? '0 : load_word;
            mis_q  <= is_mis;
        end
    end

    // Byte-enabled store at the edge that ends DONE.
    // NOTE: the memory array has no reset branch; its contents are undefined until written.
    always_ff @(posedge clk) begin
        if (rstn && state == DONE && req_valid_i && req_opcode_i && !mis_q) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign done_act     = rstn && (state == DONE);
    assign req_ready_o  = done_act && req_valid_i;
    assign resp_valid_o = done_act && req_valid_i && !req_opcode_i;
    assign resp_data_o  = done_act ? data_q : '0;

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign_o   = done_act && mis_q;
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Testbench for dmem_resp: reset behaviour, directed vector table, abort and
// reset corner sequences, and randomized traffic against a byte-level model.
module tb_dmem_resp;

    localparam int LATENCY   = 2;
    localparam int MEM_DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_opcode = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_data = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        resp_ready = 1'b1;
`ifdef DMEM_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_resp #(
        .LATENCY(LATENCY),
        .MEM_DEPTH(MEM_DEPTH),
        .XLEN(64),
        .VIRTUAL_ADDR_LEN(64)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .req_valid_i(req_valid),
        .req_opcode_i(req_opcode),
        .req_size_i(req_size),
        .req_addr_i(req_addr),
        .req_data_i(req_data),
        .req_ready_o(req_ready),
        .resp_valid_o(resp_valid),
        .resp_data_o(resp_data),
        .resp_ready_i(resp_ready)
`ifdef DMEM_MISALIGN_CHECK_EN
        ,
        .misalign_o(misalign)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference memory: one 64-bit word per index, manipulated byte by byte.
    logic [63:0] ref_words [int];

    function automatic bit is_mis(input logic [1:0] size, input logic [63:0] addr);
`ifdef DMEM_MISALIGN_CHECK_EN
        return (int'(addr[2:0]) % (1 << size)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [63:0] ref_load(input logic [1:0] size, input logic [63:0] addr);
        int idx = int'((addr >> 3) % MEM_DEPTH);
        int off = int'(addr[2:0]);
        logic [63:0] w = ref_words.exists(idx) ? ref_words[idx] : 'x;
        logic [63:0] r = '0;
        if (is_mis(size, addr)) return '0;
        for (int b = 0; b < (1 << size); b++)
            if (off + b < 8) r[8*b +: 8] = w[8*(off+b) +: 8];
        return r;
    endfunction

    task automatic ref_store(input logic [1:0] size, input logic [63:0] addr, input logic [63:0] data);
        int idx = int'((addr >> 3) % MEM_DEPTH);
        int off = int'(addr[2:0]);
        logic [63:0] w = ref_words.exists(idx) ? ref_words[idx] : 'x;
        if (is_mis(size, addr)) return;
        for (int b = 0; b < (1 << size); b++)
            if (off + b < 8) w[8*(off+b) +: 8] = data[8*b +: 8];
        ref_words[idx] = w;
    endtask

    task automatic drive(input logic op, input logic [1:0] size, input logic [63:0] addr,
                         input logic [63:0] data);
        @(negedge clk);
        req_valid  = 1'b1;
        req_opcode = op;
        req_size   = size;
        req_addr   = addr;
        req_data   = data;
    endtask

    // Wait (bounded) for completion, check latency and handshake outputs,
    // then retire the request. With hold set, valid stays high one more cycle
    // to show the response does not repeat.
    task automatic finish(input string name, input int exp_lat, input bit hold,
                          output logic [63:0] got);
        int n = 0;
        bit seen = 1'b0;
        while (n < 20 && !seen) begin
            @(negedge clk);
            n++;
            if (req_ready) seen = 1'b1;
        end
        check($sformatf("%s latency", name), 64'(n), 64'(exp_lat));
        check($sformatf("%s resp_valid", name), 64'(resp_valid), 64'(!req_opcode));
`ifdef DMEM_MISALIGN_CHECK_EN
        check($sformatf("%s misalign", name), 64'(misalign), 64'(is_mis(req_size, req_addr)));
`endif
        got = resp_data;
        if (hold) begin
            @(negedge clk);
            check($sformatf("%s ready after", name), 64'(req_ready), 64'd0);
            check($sformatf("%s valid after", name), 64'(resp_valid), 64'd0);
            req_valid = 1'b0;
            @(negedge clk);
        end else begin
            @(posedge clk);
            #1 req_valid = 1'b0;
        end
        if (seen && req_opcode) ref_store(req_size, req_addr, req_data);
    endtask

    typedef struct {
        logic        op;
        logic [1:0]  size;
        logic [63:0] addr;
        logic [63:0] data;
        logic [63:0] exp;
    } vec_t;

    vec_t        vecs [12];
    logic [63:0] got;
    logic [63:0] exp_d;

    initial begin
        vecs[0]  = '{1'b1, 2'd3, 64'h40,   64'h1122334455667788, 64'h0};
        vecs[1]  = '{1'b0, 2'd3, 64'h40,   64'h0,                64'h1122334455667788};
        vecs[2]  = '{1'b1, 2'd0, 64'h43,   64'h55555555555555AB, 64'h0};
        vecs[3]  = '{1'b0, 2'd3, 64'h40,   64'h0,                64'h11223344AB667788};
        vecs[4]  = '{1'b0, 2'd1, 64'h42,   64'h0,                64'h000000000000AB66};
        vecs[5]  = '{1'b1, 2'd2, 64'h46,   64'h00000000DEADBEEF, 64'h0};
        vecs[6]  = '{1'b0, 2'd3, 64'h40,   64'h0,                64'hBEEF3344AB667788};
        vecs[7]  = '{1'b0, 2'd2, 64'h45,   64'h0,                64'h0000000000BEEF33};
        vecs[8]  = '{1'b1, 2'd3, 64'h2040, 64'hCAFEF00D12345678, 64'h0};
        vecs[9]  = '{1'b0, 2'd3, 64'h40,   64'h0,                64'hCAFEF00D12345678};
        vecs[10] = '{1'b0, 2'd0, 64'h47,   64'h0,                64'h00000000000000CA};
        vecs[11] = '{1'b0, 2'd2, 64'h44,   64'h0,                64'h00000000CAFEF00D};

        // Reset held with a request pending: all outputs stay 0.
        drive(1'b1, 2'd3, 64'h40, 64'h0102030405060708);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset ready %0d", i), 64'(req_ready), 64'd0);
            check($sformatf("reset resp_valid %0d", i), 64'(resp_valid), 64'd0);
            check($sformatf("reset resp_data %0d", i), resp_data, 64'd0);
        end
        rstn = 1'b1;
        finish("post-reset store", LATENCY, 1'b0, got);

`ifndef DMEM_MISALIGN_CHECK_EN
        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].op, vecs[i].size, vecs[i].addr, vecs[i].data);
            finish($sformatf("vec%0d", i), LATENCY, 1'b0, got);
            if (!vecs[i].op) check($sformatf("vec%0d data", i), got, vecs[i].exp);
        end
`else
        // Misaligned load bypasses WAIT and returns zero.
        drive(1'b1, 2'd3, 64'h40, 64'h1122334455667788);
        finish("mis setup", LATENCY, 1'b0, got);
        drive(1'b0, 2'd2, 64'h42, 64'h0);
        finish("mis load", 1, 1'b0, got);
        check("mis load data", got, 64'd0);
        drive(1'b1, 2'd1, 64'h41, 64'hFFFF);
        finish("mis store", 1, 1'b0, got);
        drive(1'b0, 2'd3, 64'h40, 64'h0);
        finish("mis reload", LATENCY, 1'b0, got);
        check("mis reload data", got, 64'h1122334455667788);
`endif

        // Abort in WAIT: no completion, then a fresh store completes normally.
        drive(1'b0, 2'd3, 64'h40, 64'h0);
        @(negedge clk);
        check("abort wait ready", 64'(req_ready), 64'd0);
        req_valid = 1'b0;
        @(negedge clk);
        check("abort ready", 64'(req_ready), 64'd0);
        check("abort resp_valid", 64'(resp_valid), 64'd0);
        drive(1'b1, 2'd3, 64'h40, 64'h0BADF00D0BADF00D);
        finish("post-abort store", LATENCY, 1'b0, got);

        // Valid dropped in DONE: no outputs, no write.
        drive(1'b1, 2'd3, 64'h40, 64'hFFFFFFFFFFFFFFFF);
        @(posedge clk);
        repeat (LATENCY - 1) @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("done-drop ready", 64'(req_ready), 64'd0);
        check("done-drop resp_valid", 64'(resp_valid), 64'd0);

        // Reset mid-request: store dropped.
        drive(1'b1, 2'd3, 64'h40, 64'hEEEEEEEEEEEEEEEE);
        @(negedge clk);
        rstn = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("midreset ready", 64'(req_ready), 64'd0);
        rstn = 1'b1;

        // resp_ready low: single-pulse response carrying unchanged data.
        resp_ready = 1'b0;
        exp_d = ref_load(2'd3, 64'h40);
        drive(1'b0, 2'd3, 64'h40, 64'h0);
        finish("no-ready load", LATENCY, 1'b1, got);
        check("no-ready load data", got, exp_d);
        resp_ready = 1'b1;

        // Randomized traffic over words 8..15 with address aliasing.
        for (int w = 8; w < 16; w++) begin
            drive(1'b1, 2'd3, 64'(w * 8), {$urandom, $urandom});
            finish($sformatf("init w%0d", w), LATENCY, 1'b0, got);
        end
        for (int i = 0; i < 80; i++) begin
            logic        op   = 1'($urandom_range(0, 1));
            logic [1:0]  size = 2'($urandom_range(0, 3));
            logic [63:0] addr = 64'($urandom_range(0, 3)) * 64'(MEM_DEPTH * 8)
                              + 64'($urandom_range(8, 15) * 8) + 64'($urandom_range(0, 7));
            resp_ready = 1'($urandom_range(0, 1));
            exp_d = ref_load(size, addr);
            drive(op, size, addr, {$urandom, $urandom});
            finish($sformatf("rnd%0d", i), is_mis(size, addr) ? 1 : LATENCY, 1'b0, got);
            if (!op) check($sformatf("rnd%0d data", i), got, exp_d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder at the dcache end of the LSU request/response interface. Accepts one load or store at a time from the LSU control unit, waits a fixed access latency, then completes. Completion is `req_ready_o`, plus `resp_valid_o` with data for loads. Backed by an internal word array; it serves as the dcache model for core-level simulation and bring-up.

## Interface
Parameters:
- `LATENCY`, default 2: cycles from request detection to completion cycle; legal range ≥1.
- `MEM_DEPTH`, default 1024: number of XLEN-bit words; power of two.
- `XLEN`, `VIRTUAL_ADDR_LEN`: taken from `params.vh`.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  clock.
- `rstn`  in  1  synchronous active-low reset.
- `req_valid_i`  in  1  request present; initiator holds all `req_*` stable until `req_ready_o`.
- `req_opcode_i`  in  1  0 = load, 1 = store.
- `req_size_i`  in  2  access size: 0 = 1B, 1 = 2B, 2 = 4B, 3 = 8B.
- `req_addr_i`  in  VIRTUAL_ADDR_LEN  byte address.
- `req_data_i`  in  XLEN  store data, right-justified.
- `req_ready_o`  out  1  completion pulse; request consumed this cycle.
- `resp_valid_o`  out  1  load data valid, one-cycle pulse.
- `resp_data_o`  out  XLEN  load data, zero-extended, right-justified.
- `resp_ready_i`  in  1  accepted but not used for flow control; the response is never held.
- `misalign_o`  out  1  present only with `DMEM_MISALIGN_CHECK_EN`.

## Operation
- Word index = `req_addr_i[3 +: log2(MEM_DEPTH)]`; upper address bits ignored, so addresses alias. Byte offset = `req_addr_i[2:0]`.
- FSM states: IDLE, WAIT, DONE.
  - IDLE & `req_valid_i`:
    - Load cnt = LATENCY-1.
    - Go to DONE if LATENCY==1, else to WAIT.
  - WAIT: decrement cnt. Go to DONE when cnt==1. If `req_valid_i` is low in any WAIT cycle, abort to IDLE.
  - DONE: go to IDLE unconditionally.
- Load data capture: on entry to DONE, capture into a register the memory word shifted right by 8×offset and masked to the size. `resp_data_o` = that register in DONE, else 0.
- Completion outputs, combinational from state: `req_ready_o` = DONE & `req_valid_i`; `resp_valid_o` = DONE & `req_valid_i` & ~`req_opcode_i`.
- Store write: at the clock edge ending DONE, when `req_valid_i` & `req_opcode_i`.
  - Byte-enable write of `req_data_i` shifted left by 8×offset.
  - Bytes that would fall beyond the 8-byte word boundary are dropped. This also applies to misaligned loads: missing bytes read as 0.
- A store followed by a load to the same word returns the newly written data.
- Memory contents are not reset.
- Reset: state = IDLE and cnt = 0. All outputs read 0 while `rstn` is low and on the first cycle after release. Reset asserted mid-request drops the request: no write, no response.

## Timing
- Request first seen in IDLE at cycle T → completion (`req_ready_o`, plus `resp_valid_o` for loads) at cycle T+LATENCY.
- Next request is detected no earlier than T+LATENCY+1. Throughput is one access per LATENCY+1 cycles.
- Load completion: `req_ready_o` and `resp_valid_o` rise in the same cycle. The initiator keeps `req_valid_i` high from T through completion.
- `req_valid_i` deasserted during WAIT → IDLE next cycle, no side effects.
- `req_valid_i` deasserted during DONE → no outputs, no write, IDLE next cycle.
- `resp_ready_i` low never delays or extends `resp_valid_o`.

## Configuration
- `DMEM_MISALIGN_CHECK_EN` defined:
  - A request is misaligned when `req_addr_i` mod 2^size ≠ 0.
  - A misaligned request seen in IDLE bypasses WAIT and goes straight to DONE, completing at T+1.
  - In DONE: `misalign_o` = 1; `req_ready_o` = 1; `resp_valid_o` = 1 if it is a load, with `resp_data_o` = 0; no memory write.
  - `misalign_o` is 0 in all other cycles.
- `DMEM_MISALIGN_CHECK_EN` undefined:
  - No `misalign_o` port.
  - Misaligned accesses follow normal latency with the truncation rule above.

## Test plan
- Reset then idle: hold `rstn`=0 for 3 cycles with `req_valid_i`=1 → `req_ready_o`, `resp_valid_o`, `resp_data_o` all 0; first completion comes LATENCY cycles after release.
- Store then load, LATENCY=2: store 8B 0x1122334455667788 @0x40 at T → `req_ready_o` at T+2. Load 8B @0x40 at T+3 → `resp_valid_o` at T+5 with data 0x1122334455667788.
- Sub-word access:
  - Store 1B 0xAB @0x43 → the load 8B @0x40 returns 0x11223344AB667788.
  - Load 2B @0x42 → 0x0000000000AB66.
- Abort: load seen at T, `req_valid_i` dropped at T+1 → no `resp_valid_o` and no `req_ready_o`; a new store at T+3 completes at T+5.
- Ignored `resp_ready_i` and aliasing: `resp_ready_i` held 0 during a load → `resp_valid_o` is still a single pulse. Store @(0x40 + MEM_DEPTH×8) → the load @0x40 returns the stored value.
- Macro on: load 4B @0x42 → completes at T+1 with `misalign_o`=1, `resp_data_o`=0, memory unchanged.
